// File: rtl/data_mem_ctrl.sv
// Data-memory slave for the core LD/ST port: two-phase valid/yumi handshake,
// word-organised array with byte-lane stores and a programmable access latency.

package data_mem_ctrl_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  mem_in_s  mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s mem_o,
    output logic     misalign_o
);

    localparam int depth_lp = 1 << addr_width_p;

    if (latency_p < 1 || latency_p > 15) begin : g_bad_latency
        $fatal(1, "data_mem_ctrl: latency_p must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e state_reg, state_next;

    logic [3:0]              count_reg;
    logic [addr_width_p-1:0] idx_reg;
    logic [1:0]              lane_reg;
    logic                    wen_reg;
    logic                    bnw_reg;
    logic                    misalign_reg;
    logic [31:0]             write_data_reg;
    logic [31:0]             read_data_reg;

    logic [31:0] mem_array [depth_lp];

    logic        accept;
    logic        access;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [3:0]  lane_we;
    logic [31:0] lane_data;

    // Bits above the word index are intentionally ignored (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[31:addr_width_p+2];

    assign accept  = (state_reg == IDLE) && mem_i.valid;
    assign access  = (state_reg == BUSY) && (count_reg == 4'd0);
    assign rd_word = mem_array[idx_reg];
    assign rd_byte = rd_word[8*lane_reg +: 8];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = access && wen_reg && (!bnw_reg || (lane_reg == 2'(gi)));
        assign lane_data[8*gi +: 8] = bnw_reg ? write_data_reg[7:0]
                                              : write_data_reg[8*gi +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mem_i.valid) state_next = BUSY;
            BUSY:    if (count_reg == 4'd0) state_next = RESP;
            RESP:    if (mem_i.yumi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_o      = '0;
        misalign_o = 1'b0;
        case (state_reg)
            IDLE: mem_o.yumi = mem_i.valid;
            RESP: begin
                mem_o.valid     = 1'b1;
                mem_o.read_data = read_data_reg;
                misalign_o      = misalign_reg;
            end
            default: ;
        endcase
    end

    // Request latch, latency counter and response data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg      <= '0;
            idx_reg        <= '0;
            lane_reg       <= '0;
            wen_reg        <= 1'b0;
            bnw_reg        <= 1'b0;
            misalign_reg   <= 1'b0;
            write_data_reg <= '0;
            read_data_reg  <= '0;
        end else if (accept) begin
            count_reg      <= 4'(latency_p - 1);
            idx_reg        <= addr_i[addr_width_p+1:2];
            lane_reg       <= addr_i[1:0];
            wen_reg        <= mem_i.wen;
            bnw_reg        <= mem_i.byte_not_word;
            misalign_reg   <= !mem_i.byte_not_word && (addr_i[1:0] != 2'b00);
            write_data_reg <= mem_i.write_data;
        end else if (state_reg == BUSY) begin
            if (count_reg != 4'd0) begin
                count_reg <= count_reg - 4'd1;
            end else if (wen_reg) begin
                read_data_reg <= '0;
            end else if (bnw_reg) begin
                read_data_reg <= {24'd0, rd_byte};
            end else begin
                read_data_reg <= rd_word;
            end
        end
    end

    // Array is not reset; an aborted access never reaches here because
    // reset forces the state out of BUSY immediately.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem_array[idx_reg][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random
// loads/stores compared against a word-array reference model.

module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     mem_i;
    logic [31:0] addr_i;
    mem_out_s    mem_o;
    logic        misalign_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [31:0] model_mem [DEPTH];

    data_mem_ctrl #(.addr_width_p(AW), .latency_p(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_i      (mem_i),
        .addr_i     (addr_i),
        .mem_o      (mem_o),
        .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input bit wen, input bit bnw, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, input bit hold_valid);
        int          idx;
        int          lane;
        logic [31:0] exp_rd;
        bit          exp_mis;
        bit          got;
        int          lat;

        idx     = int'((addr >> 2) % DEPTH);
        lane    = int'(addr & 32'd3);
        exp_mis = !bnw && (lane != 0);
        exp_rd  = 32'd0;
        if (!wen) exp_rd = bnw ? ((model_mem[idx] >> (8*lane)) & 32'hFF) : model_mem[idx];
        if (wen) begin
            if (bnw) model_mem[idx] = (model_mem[idx] & ~(32'hFF << (8*lane)))
                                      | ((wdata & 32'hFF) << (8*lane));
            else     model_mem[idx] = wdata;
        end

        @(negedge clk);
        mem_i.valid         = 1'b1;
        mem_i.wen           = wen;
        mem_i.byte_not_word = bnw;
        mem_i.write_data    = wdata;
        mem_i.yumi          = 1'b0;
        addr_i              = addr;
        #1;
        check("accept_yumi", 32'(mem_o.yumi), 32'd1);
        @(posedge clk);
        #1;
        mem_i.valid      = hold_valid;
        mem_i.write_data = $urandom;

        got = 0;
        lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (mem_o.valid) begin
                got = 1;
                lat = c;
            end else begin
                check("busy_yumi", 32'(mem_o.yumi), 32'd0);
                mem_i.yumi       = 1'($urandom_range(0, 1));
                mem_i.write_data = $urandom;
            end
        end
        mem_i.yumi = 1'b0;
        if (!got) begin
            check("valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(LAT + 1));
        check("read_data", mem_o.read_data, exp_rd);
        check("misalign", 32'(misalign_o), 32'(exp_mis));
        check("resp_yumi", 32'(mem_o.yumi), 32'd0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(mem_o.valid), 32'd1);
            check("stall_data", mem_o.read_data, exp_rd);
        end

        mem_i.yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_i.yumi = 1'b0;
        #1;
        check("valid_drop", 32'(mem_o.valid), 32'd0);
        check("idle_yumi", 32'(mem_o.yumi), 32'(hold_valid));
        mem_i.valid = 1'b0;

        $display("txn wen=%0b bnw=%0b addr=0x%08h wdata=0x%08h rd=0x%08h exp=0x%08h mis=%0b",
                 wen, bnw, addr, wdata, mem_o.read_data, exp_rd, exp_mis);
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        mem_i.valid         = 1'b1;
        mem_i.wen           = 1'b1;
        mem_i.byte_not_word = 1'b0;
        mem_i.write_data    = 32'h5;
        addr_i              = 32'h40;
        @(posedge clk);
        #1;
        mem_i.valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(mem_o.valid), 32'd0);
        check("rst_yumi", 32'(mem_o.yumi), 32'd0);
        check("rst_data", mem_o.read_data, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset during BUSY of SW 0x5 @0x40");
    endtask

    initial begin
        logic [31:0] a;
        reset  = 1'b1;
        mem_i  = '0;
        addr_i = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(mem_o.valid), 32'd0);
        check("reset_data", mem_o.read_data, 32'd0);
        check("reset_misalign", 32'(misalign_o), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) do_txn(1, 0, 32'(i * 4), $urandom, 0, 0);

        do_txn(1, 0, 32'h10, 32'hDEADBEEF, 0, 0);
        do_txn(0, 0, 32'h10, 32'h0, 0, 0);
        check("lw_deadbeef", model_mem[4], 32'hDEADBEEF);
        do_txn(1, 0, 32'h20, 32'h11223344, 0, 0);
        do_txn(1, 1, 32'h22, 32'h777777AA, 0, 0);
        do_txn(0, 0, 32'h20, 32'h0, 0, 0);
        do_txn(0, 1, 32'h23, 32'h0, 0, 0);
        do_txn(0, 0, 32'h20, 32'h0, 5, 0);
        do_txn(0, 0, 32'h21, 32'h0, 0, 0);
        do_txn(0, 0, 32'h1000, 32'h0, 0, 0);
        do_txn(0, 0, 32'h20, 32'h0, 2, 1);

        reset_mid_busy();
        do_txn(0, 0, 32'h40, 32'h0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) * 4)
                | 32'($urandom_range(0, 3));
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
